// File: rtl/multibyte_rx_if.sv
// ---------------------------------------------------------------------------
// multibyte_rx_if
// Serial-in / word-out bundle for the 16-bit UART receiver.
//   RxD       : serial line into the receiver, idle high
//   data      : received word, [7:0] first byte, [15:8] second byte
//   valid     : one-cycle strobe, data updated this cycle
//   frame_err : one-cycle strobe, word discarded
//   busy      : receiver is in the middle of a word
// master = receiver side, slave = line driver / word consumer side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface multibyte_rx_if;
    logic        RxD;
    logic [15:0] data;
    logic        valid;
    logic        frame_err;
    logic        busy;

    modport master (input RxD, output data, valid, frame_err, busy);
    modport slave  (output RxD, input data, valid, frame_err, busy);
endinterface

// File: rtl/multibyte_rx.sv
// ---------------------------------------------------------------------------
// multibyte_rx
// Receives two 8N1 frames (low byte first) and assembles them into a 16-bit
// word, strobing valid for one cycle. Bad start/stop bits or an over-long
// idle between the two bytes discard the word with a frame_err strobe.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active low
//   bus   : multibyte_rx_if.master (RxD in; data/valid/frame_err/busy out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module multibyte_rx #(
    parameter int CLKS_PER_BIT     = 10416,
    parameter int GAP_TIMEOUT_BITS = 4
) (
    input  logic           clock,
    input  logic           reset,
    multibyte_rx_if.master bus
);
    localparam int BW       = $clog2(CLKS_PER_BIT);
    localparam int GAP_CLKS = GAP_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW       = $clog2(GAP_CLKS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_MID  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t        state_reg, state_next;
    logic          rx_meta_reg, rx_s_reg;
    logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic          byte_idx_reg, byte_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    low_byte_reg, low_byte_next;
    logic [15:0]   data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          frame_err_reg, frame_err_next;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.RxD;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            byte_idx_reg  <= 1'b0;
            shift_reg     <= '0;
            low_byte_reg  <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            byte_idx_reg  <= byte_idx_next;
            shift_reg     <= shift_next;
            low_byte_reg  <= low_byte_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        // Free-running bit-period counter; wraps so DATA and STOP sample
        // every CLKS_PER_BIT clocks after the mid-start sample.
        baud_cnt_next  = (baud_cnt_reg == BAUD_LAST) ? '0 : baud_cnt_reg + 1'b1;
        gap_cnt_next   = gap_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        byte_idx_next  = byte_idx_reg;
        shift_next     = shift_reg;
        low_byte_next  = low_byte_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                byte_idx_next = 1'b0;
                if (!rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt_reg == BAUD_MID) begin
                    if (!rx_s_reg) begin
                        baud_cnt_next = '0;
                        bit_idx_next  = '0;
                        state_next    = DATA;
                    end else begin
                        // A glitch before the first byte is just noise; a
                        // glitch where the second byte should start breaks
                        // the word.
                        state_next     = IDLE;
                        frame_err_next = byte_idx_reg;
                    end
                end
            end
            DATA: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    shift_next   = {rx_s_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    if (!rx_s_reg) begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end else if (!byte_idx_reg) begin
                        low_byte_next = shift_reg;
                        byte_idx_next = 1'b1;
                        gap_cnt_next  = '0;
                        state_next    = GAP;
                    end else begin
                        data_next  = {shift_reg, low_byte_reg};
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                baud_cnt_next = '0;
                gap_cnt_next  = gap_cnt_reg + 1'b1;
                // Start edge is checked first so it wins over a coincident
                // timeout.
                if (!rx_s_reg) begin
                    byte_idx_next = 1'b1;
                    state_next    = START;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.data      = data_reg;
    assign bus.valid     = valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: doc/multibyte_rx.md
# multibyte_rx

Receive-side counterpart of the 16-bit UART transmitter. Deserialises two back-to-back 8N1 frames from the serial line, low byte first, into one 16-bit word. Presents the word with a single-cycle valid strobe. Sits directly downstream of the transmitter's TxD line (loopback or remote link) and feeds the cryptography datapath.

## Interface
- CLKS_PER_BIT, 10416, clocks per bit period (100 MHz / 9600 baud); legal range ≥ 8.
- GAP_TIMEOUT_BITS, 4, maximum idle bit-times allowed between stop bit of byte 0 and start bit of byte 1.

- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
- RxD  in  1  asynchronous serial input, idle high.
- data  out  16  received word; [7:0] = first byte, [15:8] = second byte.
- valid  out  1  one-cycle pulse, data updated this cycle.
- frame_err  out  1  one-cycle pulse, word discarded (bad start, bad stop, or gap timeout).
- busy  out  1  high in any state other than IDLE.

## Operation
- RxD passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Bit counter: baud_cnt counts 0..CLKS_PER_BIT-1 and reloads 0; width is clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, STOP, GAP.
- IDLE: on rx_s = 0, clear baud_cnt and enter START. byte_idx = 0.
- START: when baud_cnt = CLKS_PER_BIT/2 - 1 (mid start bit):
  - rx_s = 0: clear baud_cnt, bit_idx = 0, enter DATA.
  - rx_s = 1: glitch. Return to IDLE.
    - byte_idx = 0: no error.
    - byte_idx = 1: pulse frame_err.
- DATA: at each baud_cnt = CLKS_PER_BIT-1 (mid data bit), shift rx_s into shift_reg[7] (right-shift, LSB first) and increment bit_idx. After the 8th bit, enter STOP.
- STOP: at mid stop bit:
  - rx_s = 0: pulse frame_err and go to IDLE. Partial word is discarded.
  - rx_s = 1, byte_idx = 0: store byte into low_byte, set byte_idx = 1, clear gap counter, enter GAP.
  - rx_s = 1, byte_idx = 1: data ← {shift_reg, low_byte}, pulse valid, go to IDLE.
- GAP: on rx_s = 0, clear baud_cnt and enter START with byte_idx = 1.
  - Gap counter counts clocks. When it reaches GAP_TIMEOUT_BITS*CLKS_PER_BIT, pulse frame_err and go to IDLE.
  - A falling edge and the timeout in the same cycle: the edge wins.
- data holds its value between valid pulses. It is never modified on error.
- valid and frame_err are mutually exclusive and never asserted for two consecutive cycles.

## Timing
- Reset values: data = 0, valid = 0, frame_err = 0, busy = 0, state = IDLE, synchroniser flops = 1.
- Reset asserted mid-frame: all of the above are applied on the next rising edge. Any partial byte is lost. After release, the block waits in IDLE for rx_s = 0.
- Start detect latency: 2 clocks from RxD falling to rx_s low, plus 1 clock to leave IDLE.
- Sample points: mid-bit, i.e. CLKS_PER_BIT/2 after the detected start edge, then every CLKS_PER_BIT.
- valid latency: asserted on the clock after the mid-stop-bit sample of byte 1. This is about 19.5 bit periods plus 3 clocks after the falling edge of byte 0's start bit, with zero gap.
- busy: rises on the cycle the state leaves IDLE; falls on the cycle valid or frame_err pulses.
- A new start bit is accepted from the cycle after return to IDLE. The second half of the final stop bit needs no idle period.
- Back-to-back words (transmitter reloading immediately) must be received without loss.

## Test plan
- Bench runs with CLKS_PER_BIT = 16, GAP_TIMEOUT_BITS = 4.
- Nominal: send frames 0x34 then 0x12, no gap -> exactly one valid pulse, data = 0x1234, frame_err never high, busy low after the valid pulse.
- Back-to-back: send words 0xA55A, 0x00FF, 0xFFFF with no idle between frames -> three valid pulses carrying those values in order.
- Glitch/false start: 4-clock low pulse on idle RxD, then word 0xBEEF -> no frame_err, one valid with data = 0xBEEF.
- Framing error: byte 0 = 0x11 with stop bit driven 0, then word 0xCAFE -> one frame_err pulse, data unchanged, then valid with data = 0xCAFE.
- Gap timeout: byte 0 = 0x77, RxD idle 5 bit-times -> frame_err at 4×16 clocks after entering GAP, data unchanged.
- Reset mid-frame: assert reset (low) during bit 3 of byte 1 of word 0x5555 -> all outputs 0 next edge; after release, word 0x1357 -> valid with data = 0x1357.
